// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Round-robin ALU/load write-back arbiter with a busy scoreboard
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            RegWrite,
    output logic [4:0]      Rd,
    output logic [XLEN-1:0] Write_data
);

    // ptr = 0 gives the ALU priority on a tie, ptr = 1 gives the load path priority.
    logic            ptr;
    logic [31:0]     busy;
    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;
    logic            accept;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    always_comb begin
        alu_ready   = !reset && alu_valid && (!mem_valid || !ptr);
        mem_ready   = !reset && mem_valid && (!alu_valid || ptr);
        issue_ready = !reset && !busy[issue_rd];
        rs1_busy    = busy[rs1];
        rs2_busy    = busy[rs2];
        accept      = alu_ready || mem_ready;
        wb_rd       = alu_ready ? alu_rd   : mem_rd;
        wb_data     = alu_ready ? alu_data : mem_data;
    end

    // Set is applied after clear so a same-edge set/clear on one register leaves it busy.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && issue_ready && (issue_rd != 5'd0)) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (accept) begin
            clr_mask[wb_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= 1'b0;
            busy       <= '0;
            RegWrite   <= 1'b0;
            Rd         <= 5'd0;
            Write_data <= '0;
        end else begin
            busy     <= ((busy & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
            RegWrite <= accept && (wb_rd != 5'd0);
            if (accept) begin
                ptr        <= alu_ready;
                Rd         <= wb_rd;
                Write_data <= wb_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Directed self-checking bench for regfile_wb_arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_rd = 5'd0;
    logic [31:0] mem_data = 32'd0;
    logic        mem_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = 5'd0;
    logic        issue_ready;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        RegWrite;
    logic [4:0]  Rd;
    logic [31:0] Write_data;

    int passed = 0;
    int total  = 0;

    regfile_wb_arbiter #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .RegWrite(RegWrite), .Rd(Rd), .Write_data(Write_data)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        issue_valid = 1'b0; issue_rd = 5'd0;
        rs1 = 5'd0; rs2 = 5'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        alu_valid = 1'b1; mem_valid = 1'b1; issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd5;
        #1;
        total++; if (RegWrite !== 1'b0) $display("FAIL reset_regwrite got %b want 0", RegWrite); else passed++;
        total++; if (Rd !== 5'd0) $display("FAIL reset_rd got %0d want 0", Rd); else passed++;
        total++; if (Write_data !== 32'd0) $display("FAIL reset_wdata got %h want 0", Write_data); else passed++;
        total++; if ({alu_ready, mem_ready, issue_ready} !== 3'b000)
            $display("FAIL reset_readies got %b want 000", {alu_ready, mem_ready, issue_ready}); else passed++;
        total++; if (rs1_busy !== 1'b0) $display("FAIL reset_rs1_busy got %b want 0", rs1_busy); else passed++;
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_single_alu();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        total++; if ({alu_ready, mem_ready} !== 2'b10)
            $display("FAIL single_ready got %b want 10", {alu_ready, mem_ready}); else passed++;
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if ({RegWrite, Rd, Write_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
            $display("FAIL single_wb got %b/%0d/%h want 1/5/deadbeef", RegWrite, Rd, Write_data); else passed++;
        @(negedge clk);
        #1;
        total++; if (RegWrite !== 1'b0) $display("FAIL single_wb_end got %b want 0", RegWrite); else passed++;
    endtask

    task automatic test_round_robin();
        logic exp_alu;
        logic [4:0] exp_rd;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alu_valid = (i < 4); alu_rd = 5'd1; alu_data = 32'hAAAA0001;
            mem_valid = (i < 4); mem_rd = 5'd2; mem_data = 32'h55550002;
            #1;
            if (i < 4) begin
                exp_alu = ((i % 2) == 0);
                total++; if ({alu_ready, mem_ready} !== {exp_alu, !exp_alu})
                    $display("FAIL rr_grant_%0d got %b want %b", i, {alu_ready, mem_ready}, {exp_alu, !exp_alu});
                else passed++;
            end
            if (i >= 1 && i <= 4) begin
                exp_rd = (((i - 1) % 2) == 0) ? 5'd1 : 5'd2;
                total++; if ({RegWrite, Rd} !== {1'b1, exp_rd})
                    $display("FAIL rr_wb_%0d got %b/%0d want 1/%0d", i, RegWrite, Rd, exp_rd); else passed++;
            end
            if (i == 2) begin
                total++; if (Write_data !== 32'h55550002)
                    $display("FAIL rr_wdata got %h want 55550002", Write_data); else passed++;
            end
            if (i == 5) begin
                total++; if (RegWrite !== 1'b0) $display("FAIL rr_wb_end got %b want 0", RegWrite); else passed++;
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_scoreboard();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        total++; if (issue_ready !== 1'b1) $display("FAIL sb_issue_first got %b want 1", issue_ready); else passed++;
        @(negedge clk);
        rs1 = 5'd7; rs2 = 5'd8;
        #1;
        total++; if ({rs1_busy, rs2_busy} !== 2'b10)
            $display("FAIL sb_busy got %b want 10", {rs1_busy, rs2_busy}); else passed++;
        total++; if (issue_ready !== 1'b0) $display("FAIL sb_issue_again got %b want 0", issue_ready); else passed++;
        @(negedge clk);
        issue_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h00C0FFEE;
        #1;
        total++; if ({mem_ready, rs1_busy} !== 2'b11)
            $display("FAIL sb_clear_cycle got %b want 11", {mem_ready, rs1_busy}); else passed++;
        @(negedge clk);
        mem_valid = 1'b0;
        issue_rd = 5'd7;
        #1;
        total++; if ({rs1_busy, issue_ready} !== 2'b01)
            $display("FAIL sb_after_clear got %b want 01", {rs1_busy, issue_ready}); else passed++;
        total++; if ({RegWrite, Rd, Write_data} !== {1'b1, 5'd7, 32'h00C0FFEE})
            $display("FAIL sb_wb got %b/%0d/%h want 1/7/00c0ffee", RegWrite, Rd, Write_data); else passed++;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_set_clear_same();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h00000099;
        #1;
        total++; if ({issue_ready, alu_ready} !== 2'b11)
            $display("FAIL same_ready got %b want 11", {issue_ready, alu_ready}); else passed++;
        @(negedge clk);
        clear_inputs();
        rs1 = 5'd9;
        #1;
        total++; if (rs1_busy !== 1'b1) $display("FAIL same_busy got %b want 1", rs1_busy); else passed++;
        total++; if ({RegWrite, Rd} !== {1'b1, 5'd9})
            $display("FAIL same_wb got %b/%0d want 1/9", RegWrite, Rd); else passed++;
        issue_rd = 5'd0;
        #1;
        total++; if (issue_ready !== 1'b1) $display("FAIL issue_rd0_ready got %b want 1", issue_ready); else passed++;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_rd_zero();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h00001234;
        #1;
        total++; if (alu_ready !== 1'b1) $display("FAIL rd0_ready got %b want 1", alu_ready); else passed++;
        @(negedge clk);
        alu_rd = 5'd3; alu_data = 32'h1;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h2;
        #1;
        total++; if (RegWrite !== 1'b0) $display("FAIL rd0_no_write got %b want 0", RegWrite); else passed++;
        total++; if ({alu_ready, mem_ready} !== 2'b01)
            $display("FAIL rd0_next_tie got %b want 01", {alu_ready, mem_ready}); else passed++;
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if ({RegWrite, Rd} !== {1'b1, 5'd4})
            $display("FAIL rd0_mem_wb got %b/%0d want 1/4", RegWrite, Rd); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd3;
        @(negedge clk);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hCAFE0004;
        rs1 = 5'd3;
        #1;
        total++; if ({rs1_busy, alu_ready} !== 2'b11)
            $display("FAIL mid_pre got %b want 11", {rs1_busy, alu_ready}); else passed++;
        @(negedge clk);
        reset = 1'b1;
        mem_valid = 1'b1; issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        total++; if (RegWrite !== 1'b0) $display("FAIL mid_regwrite got %b want 0", RegWrite); else passed++;
        total++; if (rs1_busy !== 1'b0) $display("FAIL mid_busy3 got %b want 0", rs1_busy); else passed++;
        total++; if ({alu_ready, mem_ready, issue_ready} !== 3'b000)
            $display("FAIL mid_readies got %b want 000", {alu_ready, mem_ready, issue_ready}); else passed++;
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        #1;
        total++; if (RegWrite !== 1'b0) $display("FAIL mid_no_pulse got %b want 0", RegWrite); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_round_robin();
        test_scoreboard();
        test_set_clear_same();
        test_rd_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
